// File: rtl/ramb4_s8_port_ctrl.sv
// Request/response initiator for a 512x8 single-port block RAM with optional post-reset clear sweep.
// Latency: read response valid 2 cycles after the request handshake when the response FIFO is empty.
// Backpressure: REQ_READY drops when FIFO entries plus in-flight reads would exceed RSP_DEPTH.
// Optional feature macro: RAMB4_CTRL_WRITE_ACK_EN (writes also return a response, flagged on RSP_WE).
module ramb4_s8_port_ctrl #(
   parameter int         RSP_DEPTH      = 2,
   parameter bit         CLEAR_ON_RESET = 1'b1,
   parameter logic [7:0] CLEAR_VALUE    = 8'h00
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       REQ_VALID,
   output logic       REQ_READY,
   input  logic       REQ_WE,
   input  logic [8:0] REQ_ADDR,
   input  logic [7:0] REQ_DATA,
   output logic       RSP_VALID,
   input  logic       RSP_READY,
   output logic [7:0] RSP_DATA,
`ifdef RAMB4_CTRL_WRITE_ACK_EN
   output logic       RSP_WE,
`endif
   output logic       INIT_DONE,
   output logic [8:0] RAM_ADDR,
   output logic [7:0] RAM_DI,
   output logic       RAM_EN,
   output logic       RAM_WE,
   output logic       RAM_RST,
   input  logic [7:0] RAM_DO
);

   localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CW = $clog2(RSP_DEPTH + 1);
`ifdef RAMB4_CTRL_WRITE_ACK_EN
   localparam int EW = 9;
`else
   localparam int EW = 8;
`endif

   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [8:0]    clr_addr;
   logic [EW-1:0] fifo_mem [RSP_DEPTH];
   logic [EW-1:0] push_entry;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [CW:0]   used;
   logic          pend;
   logic          accept;
   logic          push;
   logic          pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Credits in use this cycle: stored entries plus the read landing now, minus the entry leaving.
   assign used      = (CW+1)'(count) + (CW+1)'(pend) - (CW+1)'(pop);
   assign accept    = REQ_VALID & REQ_READY;
   assign push      = pend;
   assign pop       = RSP_VALID & RSP_READY;
   assign RSP_VALID = (count != '0);
   assign RSP_DATA  = fifo_mem[rd_ptr][7:0];
   assign RAM_RST   = 1'b0;

`ifdef RAMB4_CTRL_WRITE_ACK_EN
   logic pend_we;
   // RAM is write-first, so DO on the cycle after a write already carries the written byte.
   assign push_entry = {pend_we, RAM_DO};
   assign RSP_WE     = fifo_mem[rd_ptr][8];

   // Remember whether the access landing next cycle was a write.
   always_ff @(posedge CLK) begin
      if (!RST_N) pend_we <= 1'b0;
      else        pend_we <= accept & REQ_WE;
   end
`else
   assign push_entry = RAM_DO;
`endif

   // State register; reset picks the clear sweep or goes straight to RUN.
   always_ff @(posedge CLK) begin
      if (!RST_N) state <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      else        state <= state_nxt;
   end

   // Next state and RAM port drive; RAM accesses are suppressed while reset is held.
   always_comb begin
      state_nxt = state;
      REQ_READY = 1'b0;
      RAM_EN    = 1'b0;
      RAM_WE    = 1'b0;
      RAM_ADDR  = REQ_ADDR;
      RAM_DI    = REQ_DATA;
      INIT_DONE = 1'b0;
      case (state)
         ST_CLEAR: begin
            RAM_EN   = 1'b1;
            RAM_WE   = 1'b1;
            RAM_ADDR = clr_addr;
            RAM_DI   = CLEAR_VALUE;
            if (clr_addr == 9'h1FF) state_nxt = ST_RUN;
         end
         default: begin
            INIT_DONE = 1'b1;
            REQ_READY = (used < (CW+1)'(RSP_DEPTH));
            RAM_EN    = REQ_VALID & REQ_READY;
            RAM_WE    = REQ_VALID & REQ_READY & REQ_WE;
         end
      endcase
      if (!RST_N) begin
         REQ_READY = 1'b0;
         RAM_EN    = 1'b0;
         RAM_WE    = 1'b0;
      end
   end

   // Clear sweep address; wraps to 0 naturally after 511, which is when RUN is entered.
   always_ff @(posedge CLK) begin
      if (!RST_N)                clr_addr <= '0;
      else if (state == ST_CLEAR) clr_addr <= clr_addr + 9'd1;
   end

   // Pending flag: an access accepted this cycle has its DO valid next cycle.
   always_ff @(posedge CLK) begin
      if (!RST_N) pend <= 1'b0;
`ifdef RAMB4_CTRL_WRITE_ACK_EN
      else        pend <= accept;
`else
      else        pend <= accept & ~REQ_WE;
`endif
   end

   // FIFO pointers and occupancy; reset discards everything in flight.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // FIFO storage; contents need no reset because occupancy gates visibility.
   always_ff @(posedge CLK) begin
      if (push) fifo_mem[wr_ptr] <= push_entry;
   end

endmodule

// File: doc/ramb4_s8_port_ctrl.md
Name: ramb4_s8_port_ctrl

Overview:
Initiator for a single-port 512x8 block RAM (RAMB4_S8-class: 1-cycle registered read, write-first DO). It turns a valid/ready request stream into RAM port cycles, and returns read data on a valid/ready response stream backed by a credit-limited FIFO. An optional post-reset clear sweep fills the RAM with a constant before requests are accepted.

Parameters:
RSP_DEPTH, 2, response FIFO entries (2..8); also the cap on reads in flight.
CLEAR_ON_RESET, 1, 1 = run the 512-address clear sweep after reset; 0 = go straight to RUN.
CLEAR_VALUE, 8'h00, data written to every address during the clear sweep.

Ports:
CLK  in  1  clock, rising edge.
RST_N  in  1  synchronous reset, active low.
REQ_VALID  in  1  request valid.
REQ_READY  out  1  request accepted when REQ_VALID and REQ_READY are both high on the same edge.
REQ_WE  in  1  1 = write, 0 = read.
REQ_ADDR  in  9  word address.
REQ_DATA  in  8  write data.
RSP_VALID  out  1  response valid.
RSP_READY  in  1  response consumed.
RSP_DATA  out  8  read data.
INIT_DONE  out  1  high in RUN.
RAM_ADDR  out  9  to RAM ADDR.
RAM_DI  out  8  to RAM DI.
RAM_EN  out  1  to RAM EN.
RAM_WE  out  1  to RAM WE.
RAM_RST  out  1  to RAM RST; tied 0.
RAM_DO  in  8  from RAM DO.

Behaviour:
- Reset: one clock; reset is synchronous and active-low (RST_N sampled on CLK rising edge).
- Reset values:
  - state = CLEAR if CLEAR_ON_RESET, else RUN.
  - clear address = 0, FIFO empty, pending flag 0.
  - RSP_VALID = 0, INIT_DONE = 0 (1 if CLEAR_ON_RESET = 0).
  - RAM_EN and RAM_WE are forced 0 in any cycle where RST_N is low.
- State CLEAR:
  - RAM_EN = 1, RAM_WE = 1, RAM_ADDR = clear address, RAM_DI = CLEAR_VALUE.
  - Clear address increments every cycle; after address 511 is written, go to RUN. The sweep lasts exactly 512 cycles.
  - REQ_READY = 0 throughout.
- State RUN:
  - INIT_DONE = 1.
  - REQ_READY = (fifo_count + pend - pop) < RSP_DEPTH, where pop = RSP_VALID & RSP_READY. It does not depend on REQ_VALID or REQ_WE.
  - RAM_EN = REQ_VALID & REQ_READY. RAM_WE = RAM_EN & REQ_WE. RAM_ADDR = REQ_ADDR and RAM_DI = REQ_DATA, combinational pass-through.
- Read timing:
  - A read accepted in cycle N sets pend for cycle N+1.
  - In cycle N+1, RAM_DO holds the data; at the N+1 edge it is pushed into the FIFO tail.
  - RSP_VALID is high from cycle N+2. Latency is exactly 2 cycles when the FIFO is empty.
- Back-to-back reads sustain 1 per cycle while RSP_READY is held high.
- Writes produce no response when the optional feature is off. A write stalls only while REQ_READY is low.
- FIFO:
  - In-order.
  - Push and pop in the same cycle keeps the count.
  - It never overflows, because credits cover the in-flight read.
  - RSP_DATA holds the head entry and is stable while RSP_VALID & !RSP_READY.
- A write followed by a read of the same address in the next cycle returns the new data; no hazard logic is needed.
- Reset mid-operation: the FIFO and pend are discarded and in-flight reads are lost. The clear sweep restarts at address 0.
- Address width: wrap is not applicable, since all 9-bit addresses are valid.

Optional Feature:
RAMB4_CTRL_WRITE_ACK_EN
- Defined:
  - Accepted writes also occupy a credit and push a response 2 cycles later.
  - RSP_DATA carries RAM_DO, which equals the written data because the RAM is write-first.
  - An extra output RSP_WE (1 bit) flags write responses.
- Undefined: writes produce no response and RSP_WE does not exist.

Test Plan:
- Reset with CLEAR_ON_RESET = 1, CLEAR_VALUE = 8'hA5:
  - INIT_DONE rises exactly 512 cycles after RST_N goes high.
  - RAM_WE is high on every sweep cycle.
  - A subsequent read of address 0x1FF returns 8'hA5.
- Write 8'h3C to address 0x010, then read 0x010 in the next cycle: RSP_VALID asserts 2 cycles after the read handshake with RSP_DATA = 8'h3C.
- Reads of addresses 0..7 back-to-back with RSP_READY = 1: 8 responses in order on 8 consecutive cycles, with no REQ_READY drop.
- RSP_READY = 0 with RSP_DEPTH = 2, issue 4 reads:
  - REQ_READY drops after the 2nd accept.
  - RSP_DATA holds steady.
  - Releasing RSP_READY drains both responses, then the remaining 2 are accepted.
- Assert RST_N = 0 for 1 cycle while 2 reads are in flight: RSP_VALID = 0 the next cycle, no stale response appears, and the sweep restarts at address 0.
- With RAMB4_CTRL_WRITE_ACK_EN defined, write 8'h5A to address 0x100: a response arrives after 2 cycles with RSP_WE = 1 and RSP_DATA = 8'h5A.
